jtbubl_pal_dma: RTL and testbench
=================================

Name: jtbubl_pal_dma

Overview:
- Palette upload engine. Copies a block of colour bytes from a source memory into the palette RAM during vertical blank.
- Drives the palette CPU-side write port: pal_cs / rnw / 9-bit address / 8-bit data, with even/odd byte selected by addr[0].
- Sits between the main CPU's RAM and the colour mixer. The game triggers a full palette refresh with one register write instead of 512 CPU writes.
- Bus ownership is negotiated with the CPU-side palette multiplexer through a req/ack pair.

Parameters:
- AW, 16, source address width.
- LEN, 512, bytes per transfer (1..512).
- WAIT_VB, 1, 1 = transfer only while LVBL low; 0 = transfer immediately.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- LVBL  input  1  vertical blank, active low.
- start  input  1  one-cycle trigger from CPU register decode.
- src_base  input  AW  source start address, sampled on accepted start.
- busy  output  1  transfer in progress or pending.
- done  output  1  one-cycle pulse at transfer completion.
- bus_req  output  1  request ownership of the palette write port.
- bus_ack  input  1  ownership granted by external mux.
- src_addr  output  AW  source read address.
- src_rd  output  1  source read request.
- src_ok  input  1  source data valid; read completes this cycle.
- src_data  input  8  source read data.
- pal_cs  output  1  palette chip select.
- pal_rnw  output  1  palette read/not-write.
- pal_addr  output  9  palette byte address; bit 0 selects the even/odd RAM.
- pal_dout  output  8  palette write data.

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately, also mid-transfer:
  - state IDLE, counter 0, pending 0.
  - busy=0, done=0, bus_req=0, src_rd=0, src_addr=0.
  - pal_cs=0, pal_rnw=1, pal_addr=0, pal_dout=0.
  - No partial write strobe may escape.
- States: IDLE, WAIT_BLANK, REQ, READ, WRITE, DONE.
- IDLE:
  - start=1 → latch src_base, clear counter, busy=1.
  - Next state is WAIT_BLANK (WAIT_VB=1) or REQ (WAIT_VB=0).
- WAIT_BLANK: stay while LVBL=1; LVBL=0 → REQ.
- REQ: bus_req=1; wait for bus_ack=1 → READ. bus_req stays high through READ/WRITE.
- READ:
  - src_rd=1, src_addr = base + counter, modulo 2^AW, wraps silently.
  - src_addr stays stable until src_ok.
  - On the src_ok cycle, capture src_data → WRITE.
  - Minimum 1 cycle; source latency unbounded.
- WRITE:
  - Exactly one cycle with pal_cs=1, pal_rnw=0, pal_addr=counter[8:0], pal_dout=captured byte. Counter increments.
  - If counter was LEN-1 → DONE.
  - Else if WAIT_VB=1 and LVBL=1 (blank ended) → drop bus_req, go to WAIT_BLANK, keep counter and base. Resumes at the next byte.
  - Else → READ.
- Blank ending during READ: the current read completes and its write is still issued; the pause is evaluated in WRITE only.
- DONE:
  - done=1 for one cycle, bus_req=0, pal_cs=0.
  - If pending=1 → clear pending, relatch src_base, restart as from IDLE, busy stays 1.
  - Else → IDLE, busy=0.
- start while not IDLE: set pending (one deep; further starts merge).
- start in the same cycle as DONE is also counted as pending.
- Throughput: 2 cycles/byte minimum (READ with immediate src_ok + WRITE). LEN=512 at zero-wait takes 1024 cycles from first READ to DONE.
- Outputs are registered. pal_cs is never high outside WRITE. pal_rnw=1 whenever pal_cs=0.
- bus_ack is sampled only in REQ. The mux must hold ack while bus_req is high; ack drop during READ/WRITE is unsupported.

Test Plan:
- Basic transfer: WAIT_VB=1, LVBL=0, bus_ack tied 1, src_ok=src_rd, source byte = addr[7:0]^8'h5A, src_base=16'h1000, start pulse → 512 writes, pal_addr 0..511, data (0x1000+n)[7:0]^5A, done pulse after 1024+overhead cycles, busy 0 afterwards.
- Blank gating: start with LVBL=1 → no src_rd/pal_cs until LVBL falls. Raise LVBL after write 100 → bus_req drops after the write at pal_addr 99. Next blank resumes at pal_addr 100 with src_addr base+100.
- Slow source/grant: bus_ack delayed 7 cycles, src_ok delayed 3 cycles per read → src_addr stable while waiting, exactly one pal_cs cycle per byte, no write before ack.
- Wrap and short length: LEN=4, src_base=16'hFFFE → src_addr FFFE, FFFF, 0000, 0001; pal_addr 0..3; done after 4 writes.
- Pending start: start again at byte 10 and twice more before done → exactly one extra full transfer, busy continuous, two done pulses total.
- Reset mid-write: assert rst_n=0 in a WRITE cycle → pal_cs drops immediately, all outputs at reset values. After release, no activity without a new start.

Source files
------------

// File: rtl/jtbubl_pal_dma.sv
// Palette upload engine: copies LEN source bytes into the palette RAM write port,
// optionally only during vertical blank, with req/ack bus ownership.
module jtbubl_pal_dma #(
   parameter int AW      = 16,
   parameter int LEN     = 512,
   parameter int WAIT_VB = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          LVBL,
   input  logic          start,
   input  logic [AW-1:0] src_base,
   output logic          busy,
   output logic          done,
   output logic          bus_req,
   input  logic          bus_ack,
   output logic [AW-1:0] src_addr,
   output logic          src_rd,
   input  logic          src_ok,
   input  logic [7:0]    src_data,
   output logic          pal_cs,
   output logic          pal_rnw,
   output logic [8:0]    pal_addr,
   output logic [7:0]    pal_dout
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WAIT_BLANK = 3'd1;
   localparam logic [2:0] REQ        = 3'd2;
   localparam logic [2:0] READ       = 3'd3;
   localparam logic [2:0] WRITE      = 3'd4;
   localparam logic [2:0] DONE       = 3'd5;

   localparam logic [2:0] FIRST_ST = (WAIT_VB != 0) ? WAIT_BLANK : REQ;
   localparam logic [9:0] LAST     = 10'(LEN - 1);

   logic [2:0]    state, state_nx;
   logic [9:0]    cnt, cnt_nx;
   logic [AW-1:0] base, base_nx;
   logic          pending, pending_nx;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      base_nx    = base;
      pending_nx = pending;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = FIRST_ST;
               base_nx  = src_base;
               cnt_nx   = '0;
            end
         end
         WAIT_BLANK: if (!LVBL) state_nx = REQ;
         REQ:        if (bus_ack) state_nx = READ;
         READ:       if (src_ok) state_nx = WRITE;
         WRITE: begin
            cnt_nx = cnt + 10'd1;
            if (cnt == LAST)
               state_nx = DONE;
            else if (WAIT_VB != 0 && LVBL)
               state_nx = WAIT_BLANK;
            else
               state_nx = READ;
         end
         DONE: begin
            // a start arriving in this very cycle is treated like a pending one
            if (pending || start) begin
               state_nx   = FIRST_ST;
               base_nx    = src_base;
               cnt_nx     = '0;
               pending_nx = 1'b0;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (start && state != IDLE && state != DONE)
         pending_nx = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         base     <= '0;
         pending  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bus_req  <= 1'b0;
         src_rd   <= 1'b0;
         src_addr <= '0;
         pal_cs   <= 1'b0;
         pal_rnw  <= 1'b1;
         pal_addr <= '0;
         pal_dout <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         base    <= base_nx;
         pending <= pending_nx;
         // outputs are registered copies of what the next state implies
         busy    <= state_nx != IDLE;
         done    <= state_nx == DONE;
         bus_req <= state_nx == REQ || state_nx == READ || state_nx == WRITE;
         src_rd  <= state_nx == READ;
         pal_cs  <= state_nx == WRITE;
         pal_rnw <= state_nx != WRITE;
         if (state_nx == READ)
            src_addr <= base_nx + AW'(cnt_nx);
         if (state == READ && src_ok) begin
            pal_addr <= cnt[8:0];
            pal_dout <= src_data;
         end
      end
   end

endmodule

// File: tb/tb_jtbubl_pal_dma.sv
// Directed bench for jtbubl_pal_dma: a 512-byte blank-gated instance and a
// 4-byte immediate instance, with a monitor checking every palette write.
module tb_jtbubl_pal_dma;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // 512-byte, blank-gated instance
   logic        lvbl, start, busy, done, bus_req, bus_ack, src_rd, src_ok;
   logic        pal_cs, pal_rnw;
   logic [15:0] src_base, src_addr;
   logic [7:0]  src_data, pal_dout;
   logic [8:0]  pal_addr;

   // 4-byte, immediate instance
   logic        s_lvbl, s_start, s_busy, s_done, s_bus_req, s_bus_ack, s_src_rd, s_src_ok;
   logic        s_pal_cs, s_pal_rnw;
   logic [15:0] s_src_base, s_src_addr;
   logic [7:0]  s_src_data, s_pal_dout;
   logic [8:0]  s_pal_addr;

   jtbubl_pal_dma #(.AW(16), .LEN(512), .WAIT_VB(1)) dut (
      .clk(clk), .rst_n(rst_n), .LVBL(lvbl), .start(start), .src_base(src_base),
      .busy(busy), .done(done), .bus_req(bus_req), .bus_ack(bus_ack),
      .src_addr(src_addr), .src_rd(src_rd), .src_ok(src_ok), .src_data(src_data),
      .pal_cs(pal_cs), .pal_rnw(pal_rnw), .pal_addr(pal_addr), .pal_dout(pal_dout)
   );

   jtbubl_pal_dma #(.AW(16), .LEN(4), .WAIT_VB(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .LVBL(s_lvbl), .start(s_start), .src_base(s_src_base),
      .busy(s_busy), .done(s_done), .bus_req(s_bus_req), .bus_ack(s_bus_ack),
      .src_addr(s_src_addr), .src_rd(s_src_rd), .src_ok(s_src_ok), .src_data(s_src_data),
      .pal_cs(s_pal_cs), .pal_rnw(s_pal_rnw), .pal_addr(s_pal_addr), .pal_dout(s_pal_dout)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] dat_of(input logic [15:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // source and grant models with programmable latency
   int src_lat = 0, ack_lat = 0, rd_wait = 0, req_cyc = 0;
   assign src_ok   = src_rd && (rd_wait >= src_lat);
   assign src_data = dat_of(src_addr);
   assign bus_ack  = bus_req && (req_cyc >= ack_lat);
   always @(posedge clk) begin
      rd_wait <= (src_rd && !src_ok) ? rd_wait + 1 : 0;
      req_cyc <= bus_req ? req_cyc + 1 : 0;
   end

   assign s_src_ok   = s_src_rd;
   assign s_src_data = dat_of(s_src_addr);
   assign s_bus_ack  = s_bus_req;

   // monitor for the 512-byte instance
   logic [15:0] exp_base = '0;
   int          exp_idx = 0, n_wr = 0, n_rd = 0;
   logic        prev_rd = 1'b0, prev_ok = 1'b0;
   logic [15:0] prev_addr = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (pal_cs) begin
            chk("wr_rnw", pal_rnw, 0);
            chk("wr_addr", pal_addr, exp_idx);
            chk("wr_data", pal_dout, dat_of(16'(exp_base + exp_idx)));
            chk("wr_owned", bus_req & bus_ack, 1);
            n_wr++;
            exp_idx = (exp_idx + 1) % 512;
         end else begin
            chk("idle_rnw", pal_rnw, 1);
         end
         if (src_rd) begin
            n_rd++;
            chk("rd_owned", bus_req & bus_ack, 1);
            if (prev_rd && !prev_ok) chk("rd_stable", src_addr, prev_addr);
            if (src_ok) chk("rd_addr", src_addr, 16'(exp_base + exp_idx));
         end
         prev_rd   = src_rd;
         prev_ok   = src_ok;
         prev_addr = src_addr;
      end else begin
         exp_idx = 0;
         prev_rd = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] b);
      src_base = b;
      exp_base = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic run_until_done(input int limit, output logic seen, output int span,
                                 output int req_n);
      int first_rd = -1;
      seen  = 1'b0;
      span  = 0;
      req_n = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         if (bus_req && !src_rd && !pal_cs && first_rd < 0) req_n++;
         if (src_rd && first_rd < 0) first_rd = i;
         if (done) begin
            seen = 1'b1;
            span = i - first_rd;
         end
      end
   endtask

   typedef struct {
      logic [15:0] base;
      logic [15:0] src[4];
      logic [7:0]  dat[4];
   } wrap_vec_t;

   initial begin
      wrap_vec_t   tbl[3];
      logic        seen, found;
      int          span, req_n, dn, busy_low, nr, nw;
      logic [15:0] got_src[4];
      logic [8:0]  got_pa[4];
      logic [7:0]  got_pd[4];

      tbl[0] = '{base: 16'hFFFE, src: '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001},
                 dat: '{8'hA4, 8'hA5, 8'h5A, 8'h5B}};
      tbl[1] = '{base: 16'h1234, src: '{16'h1234, 16'h1235, 16'h1236, 16'h1237},
                 dat: '{8'h6E, 8'h6F, 8'h6C, 8'h6D}};
      tbl[2] = '{base: 16'h00FF, src: '{16'h00FF, 16'h0100, 16'h0101, 16'h0102},
                 dat: '{8'hA5, 8'h5A, 8'h5B, 8'h58}};

      rst_n = 1'b0; lvbl = 1'b1; start = 1'b0; src_base = '0;
      s_lvbl = 1'b1; s_start = 1'b0; s_src_base = '0;
      repeat (3) tick();

      // reset values
      chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
      chk("rst_req", bus_req, 0);     chk("rst_rd", src_rd, 0);
      chk("rst_saddr", src_addr, 0);  chk("rst_cs", pal_cs, 0);
      chk("rst_rnw", pal_rnw, 1);     chk("rst_paddr", pal_addr, 0);
      chk("rst_pdout", pal_dout, 0);  chk("rst4_rnw", s_pal_rnw, 1);
      chk("rst4_busy", s_busy, 0);
      rst_n = 1'b1;
      tick();

      // basic full transfer at zero wait
      lvbl = 1'b0; n_wr = 0;
      pulse_start(16'h1000);
      run_until_done(1200, seen, span, req_n);
      chk("basic_done_seen", seen, 1);
      chk("basic_span", span, 1024);
      chk("basic_req_cycles", req_n, 1);
      chk("basic_writes", n_wr, 512);
      tick();
      chk("basic_done_pulse", done, 0);
      chk("basic_busy_after", busy, 0);

      // blank gating and pause/resume
      lvbl = 1'b1; n_wr = 0; n_rd = 0;
      pulse_start(16'h2345);
      repeat (20) tick();
      chk("gate_no_rd", n_rd, 0);
      chk("gate_no_req", bus_req, 0);
      chk("gate_busy", busy, 1);
      lvbl = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         tick();
         if (pal_cs && pal_addr == 9'd99) begin
            found = 1'b1;
            lvbl  = 1'b1;
         end
      end
      chk("gate_reached_99", found, 1);
      repeat (10) tick();
      chk("gate_pause_writes", n_wr, 100);
      chk("gate_pause_req", bus_req, 0);
      chk("gate_pause_busy", busy, 1);
      lvbl = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (src_rd) found = 1'b1;
      end
      chk("resume_rd_seen", found, 1);
      chk("resume_src_addr", src_addr, 16'h23A9);
      run_until_done(1200, seen, span, req_n);
      chk("gate_done_seen", seen, 1);
      chk("gate_writes", n_wr, 512);

      // slow grant and slow source
      src_lat = 3; ack_lat = 7; n_wr = 0;
      pulse_start(16'h0ABC);
      run_until_done(4000, seen, span, req_n);
      chk("slow_done_seen", seen, 1);
      chk("slow_req_cycles", req_n, 8);
      chk("slow_span", span, 2560);
      chk("slow_writes", n_wr, 512);
      src_lat = 0; ack_lat = 0;
      tick();

      // pending starts merge into one extra transfer
      n_wr = 0; dn = 0; busy_low = 0;
      pulse_start(16'h0100);
      for (int i = 0; i < 2200 && dn < 2; i++) begin
         tick();
         start = 1'b0;
         if (!busy) busy_low++;
         if (done) dn++;
         if (dn == 0 && pal_cs && (pal_addr == 9'd10 || pal_addr == 9'd200 || pal_addr == 9'd300))
            start = 1'b1;
      end
      start = 1'b0;
      chk("pend_dones", dn, 2);
      chk("pend_busy_cont", busy_low, 0);
      chk("pend_writes", n_wr, 1024);
      tick();
      chk("pend_busy_after", busy, 0);
      repeat (30) tick();
      chk("pend_no_third", n_wr, 1024);

      // asynchronous reset in a write cycle
      pulse_start(16'h0300);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (pal_cs && pal_addr == 9'd5) found = 1'b1;
      end
      chk("rmw_reached_write", found, 1);
      rst_n = 1'b0;
      #1;
      chk("rmw_cs", pal_cs, 0);       chk("rmw_rnw", pal_rnw, 1);
      chk("rmw_busy", busy, 0);       chk("rmw_req", bus_req, 0);
      chk("rmw_rd", src_rd, 0);       chk("rmw_saddr", src_addr, 0);
      chk("rmw_paddr", pal_addr, 0);  chk("rmw_pdout", pal_dout, 0);
      chk("rmw_done", done, 0);
      tick();
      rst_n = 1'b1;
      n_wr = 0; n_rd = 0;
      repeat (40) tick();
      chk("rmw_quiet_rd", n_rd, 0);
      chk("rmw_quiet_wr", n_wr, 0);
      chk("rmw_quiet_busy", busy, 0);

      // short transfers with address wrap, table driven
      for (int r = 0; r < 3; r++) begin
         s_src_base = tbl[r].base;
         s_start = 1'b1;
         tick();
         s_start = 1'b0;
         nr = 0; nw = 0; seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (s_src_rd && s_src_ok) begin
               if (nr < 4) got_src[nr] = s_src_addr;
               nr++;
            end
            if (s_pal_cs) begin
               if (nw < 4) begin
                  got_pa[nw] = s_pal_addr;
                  got_pd[nw] = s_pal_dout;
               end
               nw++;
            end
            if (s_done) seen = 1'b1;
         end
         chk($sformatf("wrap%0d_done", r), seen, 1);
         chk($sformatf("wrap%0d_reads", r), nr, 4);
         chk($sformatf("wrap%0d_writes", r), nw, 4);
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("wrap%0d_src%0d", r, j), got_src[j], tbl[r].src[j]);
            chk($sformatf("wrap%0d_pa%0d", r, j), got_pa[j], j);
            chk($sformatf("wrap%0d_pd%0d", r, j), got_pd[j], tbl[r].dat[j]);
         end
         tick();
         chk($sformatf("wrap%0d_busy", r), s_busy, 0);
      end

      // start arriving in the DONE cycle restarts once
      s_src_base = 16'h0040;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      dn = 0; nw = 0; busy_low = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         s_start = 1'b0;
         if (s_pal_cs) nw++;
         if (dn < 2 && !s_busy) busy_low++;
         if (s_done) begin
            dn++;
            if (dn == 1) s_start = 1'b1;
         end
      end
      chk("dstart_dones", dn, 2);
      chk("dstart_writes", nw, 8);
      chk("dstart_busy_cont", busy_low, 0);
      chk("dstart_busy_after", s_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
